// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared state encoding and counter width for the 111 detector
package seq_det_pkg;

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      S3 = 2'b11
   } state_t;

   localparam int CNT_W = 8;

endpackage

// File: rtl/seq_det_match_cnt.sv
// rtl/seq_det_match_cnt.sv - saturating match counter, cleared by synchronous active-high rst
module seq_det_match_cnt
   import seq_det_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] match_cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign match_cnt = cnt_q;

endmodule

// File: rtl/seq_det_111_no.sv
// rtl/seq_det_111_no.sv - non-overlapping 111 Moore detector; SEQ_DET_CNT_EN adds match_cnt
module seq_det_111_no
   import seq_det_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   output logic             dout,
   output logic [1:0]       state
`ifdef SEQ_DET_CNT_EN
   ,
   output logic [CNT_W-1:0] match_cnt
`endif
);

   state_t state_q;
   state_t state_d;

   // S3 restarts at S1 on a 1 so the bits of a completed match are never reused
   always_comb begin
      state_d = S0;
      case (state_q)
         S0:      state_d = din ? S1 : S0;
         S1:      state_d = din ? S2 : S0;
         S2:      state_d = din ? S3 : S0;
         S3:      state_d = din ? S1 : S0;
         default: state_d = S0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S0;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;
   assign dout  = (state_q == S3);

`ifdef SEQ_DET_CNT_EN
   seq_det_match_cnt u_match_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (state_d == S3),
      .match_cnt (match_cnt)
   );
`endif

endmodule

// File: tb/tb_seq_det_111_no.sv
// tb/tb_seq_det_111_no.sv - scoreboard bench for seq_det_111_no; SEQ_DET_CNT_EN adds counter checks
module tb_seq_det_111_no;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       din = 1'b0;
   logic       dout;
   logic [1:0] state;
`ifdef SEQ_DET_CNT_EN
   logic [7:0] match_cnt;
`endif

   typedef struct {
      logic [1:0] st;
      logic       o;
      string      nm;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   seq_det_111_no dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .dout      (dout),
      .state     (state)
`ifdef SEQ_DET_CNT_EN
      ,
      .match_cnt (match_cnt)
`endif
   );

   // Monitor: one expectation is consumed per rising edge the driver issued
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         if (state !== mon_e.st || dout !== mon_e.o) begin
            errors++;
            $display("FAIL %s: got state=%b dout=%b, expected state=%b dout=%b",
                     mon_e.nm, state, dout, mon_e.st, mon_e.o);
         end
      end
   end

   task automatic step(input logic r, input logic d, input logic [1:0] st, input logic o,
                       input string nm);
      exp_t e;
      @(negedge clk);
      rst  = r;
      din  = d;
      e.st = st;
      e.o  = o;
      e.nm = nm;
      exp_q.push_back(e);
      @(posedge clk);
   endtask

`ifdef SEQ_DET_CNT_EN
   task automatic chk_cnt(input logic [7:0] want, input string nm);
      #1;
      checks++;
      if (match_cnt !== want) begin
         errors++;
         $display("FAIL %s: got match_cnt=%h, expected %h", nm, match_cnt, want);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset held two edges with din=1
      step(1, 1, 2'b00, 0, "reset_e1");
      step(1, 1, 2'b00, 0, "reset_e2");
      // basic match
      step(0, 1, 2'b01, 0, "basic_b1");
      step(0, 1, 2'b10, 0, "basic_b2");
      step(0, 1, 2'b11, 1, "basic_b3");
      step(0, 0, 2'b00, 0, "basic_drop");
      // non-overlapping run of nine 1s
      step(0, 1, 2'b01, 0, "run_e1");
      step(0, 1, 2'b10, 0, "run_e2");
      step(0, 1, 2'b11, 1, "run_e3");
      step(0, 1, 2'b01, 0, "run_e4");
      step(0, 1, 2'b10, 0, "run_e5");
      step(0, 1, 2'b11, 1, "run_e6");
      step(0, 1, 2'b01, 0, "run_e7");
      step(0, 1, 2'b10, 0, "run_e8");
      step(0, 1, 2'b11, 1, "run_e9");
      step(0, 0, 2'b00, 0, "run_end");
      // break: 1,1,0,1,1,1
      step(0, 1, 2'b01, 0, "brk_e1");
      step(0, 1, 2'b10, 0, "brk_e2");
      step(0, 0, 2'b00, 0, "brk_e3");
      step(0, 1, 2'b01, 0, "brk_e4");
      step(0, 1, 2'b10, 0, "brk_e5");
      step(0, 1, 2'b11, 1, "brk_e6");
      step(0, 0, 2'b00, 0, "brk_end");
      // reset mid-pattern from S2, then one fresh 1
      step(0, 1, 2'b01, 0, "rmid_e1");
      step(0, 1, 2'b10, 0, "rmid_e2");
      step(1, 1, 2'b00, 0, "rmid_rst");
      step(0, 1, 2'b01, 0, "rmid_after");
      step(0, 1, 2'b10, 0, "rmid_after2");
      // reset while in S3 takes priority over din
      step(0, 1, 2'b11, 1, "rs3_match");
      step(1, 1, 2'b00, 0, "rs3_rst");
      step(0, 0, 2'b00, 0, "rs3_zero");
      // S1 then 0, S0 stays on 0
      step(0, 1, 2'b01, 0, "s1_e1");
      step(0, 0, 2'b00, 0, "s1_zero");
      step(0, 0, 2'b00, 0, "s0_zero");

`ifdef SEQ_DET_CNT_EN
      step(1, 0, 2'b00, 0, "cnt_rst");
      chk_cnt(8'h00, "cnt_reset");
      for (int i = 0; i < 900; i++) begin
         step(0, 1, (i % 3 == 0) ? 2'b01 : (i % 3 == 1) ? 2'b10 : 2'b11,
              (i % 3 == 2), "cnt_run");
         if (i == 2) chk_cnt(8'h01, "cnt_first");
         if (i == 5) chk_cnt(8'h02, "cnt_second");
      end
      chk_cnt(8'hFF, "cnt_saturate");
      step(1, 1, 2'b00, 0, "cnt_clr_rst");
      chk_cnt(8'h00, "cnt_clear");
`endif

      for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
